riscv_ldst_ahb_sram: RTL

AHB-Lite slave data memory that sits directly downstream of the core's ldst AHB-Lite master port, and consumes its address/data-phase transfers.
- Implements a word-organised, byte-writable local RAM with a configurable number of wait states.
- Decodes an address window and checks alignment.
- Returns the standard two-cycle AHB ERROR response for illegal transfers.

---
 rtl/riscv_ahb_pkg.sv | 36 +++
 rtl/riscv_sram_byte_array.sv | 32 +++
 rtl/riscv_ldst_ahb_sram.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/riscv_ahb_pkg.sv
// Shared AHB-Lite codes, the SRAM slave FSM state type and the byte-enable helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian lane enables for a transfer of the given size at addr[1:0].
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/riscv_sram_byte_array.sv
// Word-organised RAM with a 4-lane byte-enabled synchronous write and async read.
// Latency: write commits at the clock edge; read is combinational from i_idx.
// Backpressure: none; always accepts.
// Ports: i_clk, i_we, i_be (lane enables), i_idx (word index), i_wdata, o_rdata.
module riscv_sram_byte_array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // No reset: RAM contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int l = 0; l < 4; l++) begin
                if (i_be[l]) begin
                    r_mem[i_idx][8*l +: 8] <= i_wdata[8*l +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/riscv_ldst_ahb_sram.sv
// AHB-Lite slave data RAM for the ldst master: window decode, alignment check, ERROR response.
// Latency: legal transfer completes WAIT_STATES cycles after the first data-phase cycle; errors take 2 cycles.
// Backpressure: HREADYOUT low during wait states and ERR1; new address phases accepted only while HREADYOUT=1.
// Ports: CLK/RST, AHB-Lite slave inputs (HSEL..HREADY), outputs HRDATA, HREADYOUT, HRESP.
module riscv_ldst_ahb_sram import riscv_ahb_pkg::*; #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WS          = 4'(WAIT_STATES);

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_hreadyout;
    logic          r_hresp;
    logic [AW-1:0] r_idx;
    logic          r_write;
    logic [3:0]    r_be;

    logic          w_active;
    logic          w_aligned;
    logic [31:0]   w_offset;
    logic          w_in_range;
    logic          w_legal;
    logic          w_capture;
    logic          w_complete;
    logic          w_we;
    logic [31:0]   w_rdata;
    logic          w_unused_ok;

    // Burst type, protection and lock carry no meaning for a flat RAM.
    assign w_unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    always_comb begin
        w_active = 1'b0;
        case (HTRANS)
            HTRANS_IDLE, HTRANS_BUSY: w_active = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: w_active = 1'b1;
            default: w_active = 1'b0;
        endcase
    end

    always_comb begin
        w_aligned = 1'b0;
        case (HSIZE)
            HSIZE_BYTE: w_aligned = 1'b1;
            HSIZE_HALF: w_aligned = ~HADDR[0];
            HSIZE_WORD: w_aligned = (HADDR[1:0] == 2'b00);
            default:    w_aligned = 1'b0;
        endcase
    end

    // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
    assign w_offset   = HADDR - BASE_ADDR;
    assign w_in_range = (w_offset < DEPTH_BYTES);
    assign w_legal    = w_aligned & w_in_range;
    assign w_capture  = HSEL & HREADY & w_active;

    // Completing cycle of a legal transfer: WAIT with the counter drained.
    assign w_complete = (r_state == ST_WAIT) & r_hreadyout;
    // A reset on the committing edge drops the write.
    assign w_we       = w_complete & r_write & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_idx       <= '0;
            r_write     <= 1'b0;
            r_be        <= 4'd0;
        end else if (!r_hreadyout) begin
            // Stalled states: ERR1 or a WAIT with cycles left to burn.
            if (r_state == ST_ERR1) begin
                r_state     <= ST_ERR2;
                r_hreadyout <= 1'b1;
                r_hresp     <= HRESP_ERROR;
            end else begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_hreadyout <= 1'b1;
                end
            end
        end else if (w_capture) begin
            // IDLE, completing WAIT and ERR2 all accept a new address phase.
            r_idx   <= w_offset[AW+1:2];
            r_write <= HWRITE & w_legal;
            r_be    <= byte_en(HSIZE, HADDR[1:0]);
            if (w_legal) begin
                r_state     <= ST_WAIT;
                r_cnt       <= WS;
                r_hreadyout <= (WS == 4'd0);
                r_hresp     <= HRESP_OKAY;
            end else begin
                r_state     <= ST_ERR1;
                r_cnt       <= 4'd0;
                r_hreadyout <= 1'b0;
                r_hresp     <= HRESP_ERROR;
            end
        end else begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end
    end

    riscv_sram_byte_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_be    (r_be),
        .i_idx   (r_idx),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

    assign HRDATA    = (w_complete & ~r_write) ? w_rdata : 32'd0;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

endmodule
